// File: rtl/usb_txn_engine.sv
// USB device transaction engine: decodes tokens, sequences data/handshake phases,
// and tracks per-endpoint data toggles for both directions.
module usb_txn_engine #(
  parameter int unsigned NUM_EP            = 4,
  parameter int unsigned TURNAROUND_CYCLES = 72
) (
  input  logic              clk48,
  input  logic              reset,
  input  logic              bus_reset,
  input  logic [6:0]        dev_addr,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_good,
  input  logic [3:0]        rx_pid,
  input  logic [6:0]        rx_addr,
  input  logic [3:0]        rx_endp,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_ready,
  output logic [3:0]        ep_sel,
  output logic              ep_dir,
  output logic              ep_setup,
  output logic              txn_active,
  output logic              ep_rx_done,
  output logic              ep_tx_done,
  output logic              ep_toggle,
  output logic              tx_req,
  output logic [3:0]        tx_pid,
  input  logic              tx_done
);

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  localparam int unsigned    CntW   = $clog2(TURNAROUND_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TURNAROUND_CYCLES);
  localparam logic [4:0]      NumEpW = 5'(NUM_EP);

  typedef enum logic [2:0] {
    StIdle,
    StToken,
    StDataRxWait,
    StDataRx,
    StDataTx,
    StHsTx,
    StHsRxWait,
    StHsRx
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  // Toggle vectors sized for the full 4-bit endpoint space; only bits below NUM_EP
  // are ever written, so the rest stay constant zero.
  logic [15:0]     tog_out_q;
  logic [15:0]     tog_in_q;
  logic [15:0]     stall_ext;
  logic [15:0]     ready_ext;
  logic            tok_ok;
  logic            data_pid_ok;
  logic            rx_data1;

  assign stall_ext   = 16'(ep_stall);
  assign ready_ext   = 16'(ep_ready);
  assign tok_ok      = rx_good && (rx_addr == dev_addr) && ({1'b0, rx_endp} < NumEpW) &&
                       ((rx_pid == PidOut) || (rx_pid == PidSetup) || (rx_pid == PidIn));
  assign data_pid_ok = (rx_pid == PidData0) || (rx_pid == PidData1);
  assign rx_data1    = (rx_pid == PidData1);
  assign ep_toggle   = ep_dir ? tog_in_q[ep_sel] : tog_out_q[ep_sel];

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tog_out_q  <= '0;
      tog_in_q   <= '0;
      ep_sel     <= '0;
      ep_dir     <= 1'b0;
      ep_setup   <= 1'b0;
      txn_active <= 1'b0;
      ep_rx_done <= 1'b0;
      ep_tx_done <= 1'b0;
      tx_req     <= 1'b0;
      tx_pid     <= '0;
    end else if (bus_reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tog_out_q  <= '0;
      tog_in_q   <= '0;
      ep_sel     <= '0;
      ep_dir     <= 1'b0;
      ep_setup   <= 1'b0;
      txn_active <= 1'b0;
      ep_rx_done <= 1'b0;
      ep_tx_done <= 1'b0;
      tx_req     <= 1'b0;
      tx_pid     <= '0;
    end else begin
      ep_rx_done <= 1'b0;
      ep_tx_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_sop) state_q <= StToken;
        end

        StToken: begin
          if (rx_eop) begin
            if (tok_ok) begin
              ep_sel     <= rx_endp;
              ep_dir     <= (rx_pid == PidIn);
              ep_setup   <= (rx_pid == PidSetup);
              txn_active <= 1'b1;
              if (rx_pid == PidIn) begin
                tx_req <= 1'b1;
                if (stall_ext[rx_endp]) begin
                  tx_pid  <= PidStall;
                  state_q <= StHsTx;
                end else if (!ready_ext[rx_endp]) begin
                  tx_pid  <= PidNak;
                  state_q <= StHsTx;
                end else begin
                  tx_pid  <= tog_in_q[rx_endp] ? PidData1 : PidData0;
                  state_q <= StDataTx;
                end
              end else begin
                state_q <= StDataRxWait;
              end
            end else begin
              state_q <= StIdle;
            end
          end
        end

        StDataTx: begin
          if (tx_done) begin
            tx_req  <= 1'b0;
            state_q <= StHsRxWait;
          end
        end

        StHsRxWait: begin
          if (rx_sop) begin
            cnt_q   <= '0;
            state_q <= StHsRx;
          end else if (cnt_q == CntMax) begin
            // Host never answered: leave the IN toggle alone so the data is resent.
            cnt_q      <= '0;
            txn_active <= 1'b0;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StHsRx: begin
          if (rx_eop) begin
            if (rx_good && (rx_pid == PidAck)) begin
              tog_in_q[ep_sel] <= ~tog_in_q[ep_sel];
              ep_tx_done       <= 1'b1;
            end
            txn_active <= 1'b0;
            state_q    <= StIdle;
          end
        end

        StDataRxWait: begin
          if (rx_sop) begin
            cnt_q   <= '0;
            state_q <= StDataRx;
          end else if (cnt_q == CntMax) begin
            cnt_q      <= '0;
            txn_active <= 1'b0;
            state_q    <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StDataRx: begin
          if (rx_eop) begin
            if (!rx_good || !data_pid_ok) begin
              txn_active <= 1'b0;
              state_q    <= StIdle;
            end else begin
              tx_req  <= 1'b1;
              state_q <= StHsTx;
              if (ep_setup) begin
                // SETUP cannot be refused; it restarts both directions at DATA1.
                tx_pid            <= PidAck;
                tog_out_q[ep_sel] <= 1'b1;
                tog_in_q[ep_sel]  <= 1'b1;
                ep_rx_done        <= 1'b1;
              end else if (stall_ext[ep_sel]) begin
                tx_pid <= PidStall;
              end else if (!ready_ext[ep_sel]) begin
                tx_pid <= PidNak;
              end else begin
                tx_pid <= PidAck;
                // A toggle mismatch is a retry of data we already took: ACK, drop it.
                if (rx_data1 == tog_out_q[ep_sel]) begin
                  tog_out_q[ep_sel] <= ~tog_out_q[ep_sel];
                  ep_rx_done        <= 1'b1;
                end
              end
            end
          end
        end

        StHsTx: begin
          if (tx_done) begin
            tx_req     <= 1'b0;
            txn_active <= 1'b0;
            state_q    <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/usb_txn_engine.md
USB_TXN_ENGINE -- requirements
Module: usb_txn_engine

Interface
REQ-001 SHALL have parameter NUM_EP, default 4, number of implemented endpoints (1..16).
REQ-002 SHALL have parameter TURNAROUND_CYCLES, default 72, clk48 cycles to wait for a host packet after our/host EOP.
REQ-003 SHALL have ports (name direction width meaning): clk48 in 1 clock; reset in 1 asynchronous, active-high reset.
REQ-004 bus_reset in 1 USB bus reset from decoder; dev_addr in 7 assigned device address.
REQ-005 rx_sop in 1 SOP pulse; rx_eop in 1 EOP pulse; rx_good in 1 packet CRC/PID ok, valid with rx_eop; rx_pid in 4; rx_addr in 7; rx_endp in 4.
REQ-006 ep_stall in NUM_EP per-endpoint halt; ep_ready in NUM_EP per-endpoint OUT buffer free / IN data loaded.
REQ-007 ep_sel out 4 active endpoint; ep_dir out 1 (1=IN); ep_setup out 1 active token was SETUP; txn_active out 1.
REQ-008 ep_rx_done out 1 pulse, OUT/SETUP data accepted; ep_tx_done out 1 pulse, IN data ACKed by host; ep_toggle out 1 toggle for current transfer.
REQ-009 tx_req out 1; tx_pid out 4; tx_done in 1 pulse from encoder when packet fully sent.

Function
REQ-010 PIDs: OUT 0001, IN 1001, SOF 0101, SETUP 1101, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
REQ-011 States: IDLE, TOKEN, DATA_RX_WAIT, DATA_RX, DATA_TX, HS_TX, HS_RX_WAIT, HS_RX.
REQ-012 IDLE->TOKEN on rx_sop; TOKEN evaluates on rx_eop.
REQ-013 Token accepted iff rx_good, rx_addr==dev_addr, rx_endp<NUM_EP, PID in {OUT,SETUP,IN}; else ->IDLE, no response.
REQ-014 Accepted token latches ep_sel, ep_dir, ep_setup, sets txn_active; OUT/SETUP->DATA_RX_WAIT; IN->DATA_TX or HS_TX.
REQ-015 IN: ep_stall -> HS_TX with STALL; else !ep_ready -> HS_TX with NAK; else DATA_TX with tx_pid DATA0/DATA1 per IN toggle.
REQ-016 DATA_TX: tx_req held high, tx_pid stable until tx_done; then HS_RX_WAIT.
REQ-017 HS_RX_WAIT: rx_sop->HS_RX; counter reaching TURNAROUND_CYCLES->IDLE, toggle unchanged, no ep_tx_done.
REQ-018 HS_RX: on rx_eop, rx_good and rx_pid==ACK -> flip IN toggle, pulse ep_tx_done; any other -> no change; ->IDLE.
REQ-019 DATA_RX_WAIT: rx_sop->DATA_RX; timeout at TURNAROUND_CYCLES->IDLE.
REQ-020 DATA_RX on rx_eop: !rx_good or PID not DATA0/DATA1 -> IDLE, no handshake.
REQ-021 SETUP data: always ACK regardless of ep_stall/ep_ready; OUT toggle:=1, IN toggle:=1; ep_rx_done pulse.
REQ-022 OUT data: ep_stall->STALL; !ep_ready->NAK; PID toggle != expected -> ACK, no ep_rx_done, toggle unchanged (duplicate); match -> ACK, ep_rx_done pulse, flip OUT toggle.
REQ-023 HS_TX: tx_req high with handshake tx_pid until tx_done, then IDLE.
REQ-024 Toggles stored per endpoint per direction (2*NUM_EP bits); ep_toggle reflects selected endpoint/direction.
REQ-025 ep_rx_done/ep_tx_done single-cycle, registered, coincident with state exit.
REQ-026 Turnaround counter: 0 outside wait states, saturates at TURNAROUND_CYCLES.
REQ-027 SOF or any token arriving in a wait state is ignored as data; packet treated by DATA_RX/HS_RX rules.
REQ-028 txn_active high from token acceptance until return to IDLE.

Reset
REQ-029 reset (async) and bus_reset (sync, highest priority) force IDLE, all toggles 0, outputs 0, counter 0.
REQ-030 bus_reset mid-transmit drops tx_req next cycle; pending pulses suppressed.

Verification
REQ-031 SETUP addr=dev_addr ep0 + DATA0 good -> tx_pid ACK, ep_rx_done one pulse, both ep0 toggles=1.
REQ-032 OUT ep1 DATA1 when expected DATA0, ep_ready=1 -> ACK sent, no ep_rx_done, toggle stays 0.
REQ-033 IN ep2 ep_ready=1 toggle 0 -> DATA0 sent; host ACK -> ep_tx_done, toggle 1; repeat with no ACK for 72 cycles -> IDLE, toggle stays 1.
REQ-034 IN ep1 ep_stall=1 -> STALL; ep_ready=0 -> NAK; token rx_endp>=NUM_EP or wrong addr -> no tx_req.
REQ-035 bus_reset asserted during DATA_TX -> tx_req low next cycle, state IDLE, all toggles 0.
